// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution window scheduler.
// Holds the FSM state encoding, output-dimension functions and the default index width.
package conv_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    function automatic int calc_result_width(int image_width, int weight_width,
                                             int stride, int padding);
        return (image_width - weight_width + 2 * padding) / stride + 1;
    endfunction

    function automatic int calc_result_length(int image_length, int weight_length,
                                              int stride, int padding);
        return (image_length - weight_length + 2 * padding) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Handshake and index bundle between the window scheduler and its controller/conv unit.
// slave = scheduler side, master = controller side driving start/abort and the result strobe.
interface conv_window_scheduler_if
    import conv_pkg::*;
#(
    parameter int addr_width = ADDR_WIDTH_DEFAULT
) ();
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  cu_conv_en;
    logic                  cu_out_valid;
    logic                  rlt_we;
    logic [addr_width-1:0] oc_idx;
    logic [addr_width-1:0] win_row;
    logic [addr_width-1:0] win_col;
    logic [addr_width-1:0] anchor_1D;
    logic [addr_width-1:0] rlt_idx;

    modport slave (
        input  start, abort, cu_out_valid,
        output busy, done, cu_conv_en, rlt_we,
        output oc_idx, win_row, win_col, anchor_1D, rlt_idx
    );

    modport master (
        output start, abort, cu_out_valid,
        input  busy, done, cu_conv_en, rlt_we,
        input  oc_idx, win_row, win_col, anchor_1D, rlt_idx
    );
endinterface

// File: rtl/conv_win_counter.sv
// Nested column/row/channel window counter with stride-step anchor adders; all outputs registered.
// Latency: one cycle from clear/advance to updated outputs; no backpressure, advance is trusted.
module conv_win_counter
    import conv_pkg::*;
#(
    parameter int output_channel = 1,
    parameter int result_width   = 78,
    parameter int result_length  = 78,
    parameter int stride         = 2,
    parameter int padded_width   = 160,
    parameter int addr_width     = ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [addr_width-1:0] oc_idx,
    output logic [addr_width-1:0] win_row,
    output logic [addr_width-1:0] win_col,
    output logic [addr_width-1:0] anchor_1D,
    output logic [addr_width-1:0] rlt_idx,
    output logic                  last
);
    localparam logic [addr_width-1:0] C_MAX    = addr_width'(result_width - 1);
    localparam logic [addr_width-1:0] R_MAX    = addr_width'(result_length - 1);
    localparam logic [addr_width-1:0] OC_MAX   = addr_width'(output_channel - 1);
    localparam logic [addr_width-1:0] STEP     = addr_width'(stride);
    localparam logic [addr_width-1:0] ROW_STEP = addr_width'(stride * padded_width);
    localparam logic [addr_width-1:0] ONE      = addr_width'(1);

    logic [addr_width-1:0] c_q, c_d, r_q, r_d, oc_q, oc_d;
    logic [addr_width-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic [addr_width-1:0] row_base_q, row_base_d, anchor_q, anchor_d;
    logic [addr_width-1:0] rlt_idx_q, rlt_idx_d;

    always_comb begin
        c_d        = c_q;
        r_d        = r_q;
        oc_d       = oc_q;
        win_row_d  = win_row_q;
        win_col_d  = win_col_q;
        row_base_d = row_base_q;
        rlt_idx_d  = rlt_idx_q;
        if (clear) begin
            c_d        = '0;
            r_d        = '0;
            oc_d       = '0;
            win_row_d  = '0;
            win_col_d  = '0;
            row_base_d = '0;
            rlt_idx_d  = '0;
        end else if (advance) begin
            // Flat result index follows sweep order, so it simply counts windows.
            rlt_idx_d = rlt_idx_q + ONE;
            if (c_q == C_MAX) begin
                c_d       = '0;
                win_col_d = '0;
                if (r_q == R_MAX) begin
                    r_d        = '0;
                    win_row_d  = '0;
                    row_base_d = '0;
                    oc_d       = oc_q + ONE;
                end else begin
                    r_d        = r_q + ONE;
                    win_row_d  = win_row_q + STEP;
                    row_base_d = row_base_q + ROW_STEP;
                end
            end else begin
                c_d       = c_q + ONE;
                win_col_d = win_col_q + STEP;
            end
        end
        anchor_d = row_base_d + win_col_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q        <= '0;
            r_q        <= '0;
            oc_q       <= '0;
            win_row_q  <= '0;
            win_col_q  <= '0;
            row_base_q <= '0;
            anchor_q   <= '0;
            rlt_idx_q  <= '0;
        end else begin
            c_q        <= c_d;
            r_q        <= r_d;
            oc_q       <= oc_d;
            win_row_q  <= win_row_d;
            win_col_q  <= win_col_d;
            row_base_q <= row_base_d;
            anchor_q   <= anchor_d;
            rlt_idx_q  <= rlt_idx_d;
        end
    end

    assign oc_idx    = oc_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign anchor_1D = anchor_q;
    assign rlt_idx   = rlt_idx_q;
    assign last      = (c_q == C_MAX) && (r_q == R_MAX) && (oc_q == OC_MAX);

endmodule

// File: rtl/conv_window_scheduler.sv
// Start/busy/done sequencer sweeping every conv output window; one enable per window, waits for result.
// Latency: start->enable 1 cycle, k+1 cycles per window; backpressure is the conv unit's result strobe.
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int output_channel = 1,
    parameter int image_width    = 160,
    parameter int image_length   = 160,
    parameter int weight_width   = 5,
    parameter int weight_length  = 5,
    parameter int stride         = 2,
    parameter int padding        = 0,
    parameter int result_width   = calc_result_width(image_width, weight_width, stride, padding),
    parameter int result_length  = calc_result_length(image_length, weight_length, stride, padding),
    parameter int addr_width     = ADDR_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    conv_window_scheduler_if.slave  sif
);
    localparam int PADDED_W = image_width + 2 * padding;

    sched_state_e state_q, state_d;
    logic busy_q, busy_d, done_q, done_d, conv_en_q, conv_en_d;
    logic last, accept, clear, advance;

    // Abort outranks a result arriving in the same cycle, so that result is dropped.
    assign accept  = (state_q == ST_WAIT) && sif.cu_out_valid && !sif.abort;
    assign clear   = (state_q == ST_IDLE) && sif.start && !sif.abort;
    assign advance = accept && !last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sif.start) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (sif.cu_out_valid) state_d = last ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (sif.abort) state_d = ST_IDLE;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        conv_en_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            conv_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            conv_en_q <= conv_en_d;
        end
    end

    conv_win_counter #(
        .output_channel (output_channel),
        .result_width   (result_width),
        .result_length  (result_length),
        .stride         (stride),
        .padded_width   (PADDED_W),
        .addr_width     (addr_width)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .advance   (advance),
        .oc_idx    (sif.oc_idx),
        .win_row   (sif.win_row),
        .win_col   (sif.win_col),
        .anchor_1D (sif.anchor_1D),
        .rlt_idx   (sif.rlt_idx),
        .last      (last)
    );

    assign sif.busy       = busy_q;
    assign sif.done       = done_q;
    assign sif.cu_conv_en = conv_en_q;
    assign sif.rlt_we     = accept && !reset;

endmodule
